pc_gen: RTL and testbench

Parametrised next-generation fetch PC generator for the MIPS pipeline. Keeps the reset-vector, stall and branch-redirect behaviour of the current PC register. Adds the following:
- a valid/ready address handshake toward the instruction SRAM interface;
- a flush/exception redirect port with priority over branches;
- a one-entry pending-redirect buffer, so a branch resolved during a stall is never lost;
- misaligned-PC (AdEL) detection.

It sits between the pipeline controller/decode stage and the instruction-side SRAM bridge.

---
 rtl/pc_gen_pkg.sv | 32 +++
 rtl/pc_gen_if.sv | 20 ++
 rtl/pc_redirect_buf.sv | 58 +++++
 rtl/pc_gen.sv | 90 +++++++++
 tb/tb_pc_gen.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the fetch PC generator: reset/enable encodings,
// the default reset vector, pending-redirect states and next-PC source select.
package pc_gen_pkg;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam int INST_ADDR_W = 32;
    typedef logic [INST_ADDR_W-1:0] inst_addr_t;

    localparam inst_addr_t RESET_VECTOR = 32'hbfc0_0000;

    typedef enum logic {
        REDIR_IDLE,
        REDIR_HELD
    } redir_state_e;

    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_FLUSH,
        NPC_BRANCH,
        NPC_PENDING,
        NPC_SEQ
    } npc_sel_e;

    // A fetch address is misaligned when either of its two low bits is set.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-address handshake between the PC generator and the instruction SRAM bridge.
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              inst_req;
    logic              inst_addr_ok;
    logic              pc_adel;

    modport master (
        output pc, ce, inst_req, pc_adel,
        input  inst_addr_ok
    );

    modport slave (
        input  pc, ce, inst_req, pc_adel,
        output inst_addr_ok
    );
endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer: remembers a branch target resolved while the
// fetch could not accept it, until it is consumed by a fire or discarded by a flush.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [ADDR_W-1:0] capture_target,
    input  logic              consume,
    input  logic              discard,
    output logic              valid,
    output logic [ADDR_W-1:0] target
);

    redir_state_e      state_q, state_d;
    logic [ADDR_W-1:0] target_q, target_d;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            REDIR_IDLE: begin
                if (capture) begin
                    state_d  = REDIR_HELD;
                    target_d = capture_target;
                end
            end
            REDIR_HELD: begin
                if (discard || consume) begin
                    state_d = REDIR_IDLE;
                end else if (capture) begin
                    target_d = capture_target;
                end
            end
            default: state_d = REDIR_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q  <= REDIR_IDLE;
            // NOTE: the target is only meaningful while HELD, but resetting it keeps it deterministic.
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    assign valid  = (state_q == REDIR_HELD);
    assign target = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: reset vector, stall hold, flush/branch/pending redirects with
// fixed priority, valid/ready address handshake and misaligned-fetch detection.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VECTOR,
    parameter int                STALL_W   = 6,
    parameter int                INC       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_pc,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    output logic               fetch_stall_req,
    pc_gen_if.master           bus
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q;
    logic              pc_adel;
    logic              inst_req;
    logic              fire;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    npc_sel_e          npc_sel;

    // Only stall[0] freezes the PC stage; the upper bits belong to later stages.
    logic unused_stall;
    assign unused_stall = &{1'b0, stall[STALL_W-1:1]};

    assign pc_adel         = ce_q & is_misaligned(pc_q[1:0]);
    assign inst_req        = ce_q & ~stall[0] & ~pc_adel & ~flush;
    assign fire            = inst_req & bus.inst_addr_ok;
    assign fetch_stall_req = inst_req & ~bus.inst_addr_ok;

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk            (clk),
        .rst            (rst),
        .capture        (ce_q & branch_flag_i & ~fire & ~flush),
        .capture_target (branch_target_address_i),
        .consume        (ce_q & fire),
        .discard        (ce_q & flush),
        .valid          (pend_valid),
        .target         (pend_target)
    );

    // Flush wins over everything; redirects other than flush only take effect on an accepted fetch.
    always_comb begin
        npc_sel = NPC_HOLD;
        if (ce_q) begin
            if (flush)                       npc_sel = NPC_FLUSH;
            else if (fire && branch_flag_i)  npc_sel = NPC_BRANCH;
            else if (fire && pend_valid)     npc_sel = NPC_PENDING;
            else if (fire)                   npc_sel = NPC_SEQ;
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (npc_sel)
            NPC_FLUSH:   pc_d = flush_pc;
            NPC_BRANCH:  pc_d = branch_target_address_i;
            NPC_PENDING: pc_d = pend_target;
            NPC_SEQ:     pc_d = pc_q + ADDR_W'(INC);
            default:     pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            pc_q <= RESET_VEC;
            ce_q <= CHIP_DISABLE;
        end else begin
            pc_q <= pc_d;
            ce_q <= CHIP_ENABLE;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.ce       = ce_q;
    assign bus.inst_req = inst_req;
    assign bus.pc_adel  = pc_adel;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, sequential fetch, handshake backpressure, pending
// branch across a stall, flush priority, misaligned PC, address wrap and async reset.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int STALL_W = 6;

    logic               clk;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  flush_pc;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_address_i;
    logic               fetch_stall_req;

    int n_checks;
    int n_pass;

    pc_gen_if #(.ADDR_W(ADDR_W)) bus ();

    pc_gen #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (32'hbfc0_0000),
        .STALL_W   (STALL_W),
        .INC       (4)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .flush_pc                (flush_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .fetch_stall_req         (fetch_stall_req),
        .bus                     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0; stall = '0; flush = 1'b0; flush_pc = '0;
        branch_flag_i = 1'b0; branch_target_address_i = '0;
        bus.inst_addr_ok = 1'b1;

        // Reset state
        #12;
        check("rst_pc",       bus.pc,          32'hbfc0_0000);
        check("rst_ce",       bus.ce,          1'b0);
        check("rst_req",      bus.inst_req,    1'b0);
        check("rst_fsr",      fetch_stall_req, 1'b0);
        check("rst_adel",     bus.pc_adel,     1'b0);

        // Reset release: ce rises after one edge, then sequential fetch
        rst = 1'b1;
        #1;
        check("rel_ce_pre",   bus.ce,          1'b0);
        tick();
        check("rel_ce",       bus.ce,          1'b1);
        check("rel_pc0",      bus.pc,          32'hbfc0_0000);
        check("rel_req",      bus.inst_req,    1'b1);
        tick(); check("seq_pc1", bus.pc, 32'hbfc0_0004);
        tick(); check("seq_pc2", bus.pc, 32'hbfc0_0008);
        tick(); check("seq_pc3", bus.pc, 32'hbfc0_000c);
        tick(); check("seq_pc4", bus.pc, 32'hbfc0_0010);

        // Backpressure: address not accepted for 3 cycles
        bus.inst_addr_ok = 1'b0;
        #1;
        check("bp_req0",      bus.inst_req,    1'b1);
        check("bp_fsr0",      fetch_stall_req, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_pc",    bus.pc,          32'hbfc0_0010);
            check("bp_req",   bus.inst_req,    1'b1);
            check("bp_fsr",   fetch_stall_req, 1'b1);
        end
        bus.inst_addr_ok = 1'b1;
        #1;
        check("bp_fsr_off",   fetch_stall_req, 1'b0);
        tick(); check("bp_accept_pc", bus.pc, 32'hbfc0_0014);

        // Branch resolved during a stall is held and used on the next fire
        stall = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'hbfc0_0100;
        #1;
        check("stall_req",    bus.inst_req,    1'b0);
        tick(); check("stall_pc1", bus.pc, 32'hbfc0_0014);
        branch_flag_i = 1'b0;
        tick(); check("stall_pc2", bus.pc, 32'hbfc0_0014);
        stall = '0;
        tick(); check("pend_pc",   bus.pc, 32'hbfc0_0100);
        tick(); check("pend_clr",  bus.pc, 32'hbfc0_0104);

        // Flush discards a pending branch even without handshake
        bus.inst_addr_ok = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'hbfc0_0200;
        tick(); check("fl_hold_pc", bus.pc, 32'hbfc0_0104);
        branch_flag_i = 1'b0; flush = 1'b1; flush_pc = 32'hbfc0_0380;
        #1;
        check("fl_req",       bus.inst_req,    1'b0);
        tick(); check("fl_pc",  bus.pc, 32'hbfc0_0380);
        flush = 1'b0; bus.inst_addr_ok = 1'b1;
        tick(); check("fl_next", bus.pc, 32'hbfc0_0384);

        // Flush has priority over a simultaneous branch
        flush = 1'b1; flush_pc = 32'hbfc0_0380;
        branch_flag_i = 1'b1; branch_target_address_i = 32'hbfc0_0500;
        tick(); check("prio_pc", bus.pc, 32'hbfc0_0380);
        flush = 1'b0; branch_flag_i = 1'b0;
        tick(); check("prio_next", bus.pc, 32'hbfc0_0384);

        // Misaligned PC suppresses the request and holds until flushed
        flush = 1'b1; flush_pc = 32'hbfc0_0382;
        tick(); check("adel_pc", bus.pc, 32'hbfc0_0382);
        flush = 1'b0;
        #1;
        check("adel_flag",    bus.pc_adel,     1'b1);
        check("adel_req",     bus.inst_req,    1'b0);
        check("adel_fsr",     fetch_stall_req, 1'b0);
        tick(); check("adel_hold", bus.pc, 32'hbfc0_0382);
        flush = 1'b1; flush_pc = 32'hbfc0_0380;
        tick(); check("adel_exit_pc", bus.pc, 32'hbfc0_0380);
        flush = 1'b0;
        #1;
        check("adel_clr",     bus.pc_adel,     1'b0);
        check("adel_req_back", bus.inst_req,   1'b1);

        // Address wrap at the top of the space
        flush = 1'b1; flush_pc = 32'hffff_fffc;
        tick(); check("wrap_pre", bus.pc, 32'hffff_fffc);
        flush = 1'b0;
        tick(); check("wrap_pc", bus.pc, 32'h0000_0000);

        // Asynchronous reset in the middle of a pending request
        bus.inst_addr_ok = 1'b0;
        #1;
        check("arst_req_pre", bus.inst_req,    1'b1);
        rst = 1'b0;
        #1;
        check("arst_pc",      bus.pc,          32'hbfc0_0000);
        check("arst_ce",      bus.ce,          1'b0);
        check("arst_req",     bus.inst_req,    1'b0);
        check("arst_fsr",     fetch_stall_req, 1'b0);

        // While ce is still low, a flush is ignored
        flush = 1'b1; flush_pc = 32'h1234_5678;
        #1;
        rst = 1'b1;
        tick();
        check("ce0_flush_pc", bus.pc,          32'hbfc0_0000);
        check("ce0_ce",       bus.ce,          1'b1);
        flush = 1'b0; bus.inst_addr_ok = 1'b1;
        tick(); check("restart_pc", bus.pc, 32'hbfc0_0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
